// File: rtl/lsu_ctrl.sv
// lsu_ctrl -- load/store unit controller for the MEM stage.
//
// Accepts one load or store from the pipeline, checks alignment, runs a
// single data-bus transaction (bus_req held until bus_ack or timeout) and
// returns the extended load result with a one-cycle rdata_valid pulse.
//
// Ports
//   clk, reset        clock (rising edge), asynchronous active-low reset
//   req_valid         MEM-stage instruction is a load or store
//   req_we            1 = store, 0 = load
//   req_swhb          access size: 01 word, 10 half, 11 byte, 00 none
//   req_unsigned      1 = zero-extend load result
//   req_addr          byte address
//   req_wdata         store data, right-justified
//   stall             hold the pipeline while the access is in flight
//   rdata_valid       one-cycle pulse, rdata valid
//   rdata             extended load result (0 for stores / timeouts)
//   misalign          one-cycle pulse, misaligned request rejected
//   bus_err           one-cycle pulse with rdata_valid, access timed out
//   bus_req, bus_we   data-bus request and write strobe
//   bus_addr          word-aligned address
//   bus_be            byte enables
//   bus_wdata         lane-replicated store data
//   bus_ack           bus completion
//   bus_rdata         read word, valid with bus_ack
//   state_dbg         current FSM state (00 IDLE, 01 BUSY, 10 DONE)
//
// Handshake: the bus side is a request/acknowledge pair. bus_req is held
// high with all bus_* fields stable for every BUSY cycle; the transfer
// completes in the cycle where bus_req=1 and bus_ack=1 are sampled on the
// same rising edge. bus_ack while bus_req=0 has no effect.
module lsu_ctrl #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  logic            req_we,
  input  logic [1:0]      req_swhb,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            stall,
  output logic            rdata_valid,
  output logic [XLEN-1:0] rdata,
  output logic            misalign,
  output logic            bus_err,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [3:0]      bus_be,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_ack,
  input  logic [XLEN-1:0] bus_rdata,
  output logic [1:0]      state_dbg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_WORD = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_BYTE = 2'b11;

  // Last counter value that still allows another BUSY cycle.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]      state;
  logic [7:0]      cnt;
  logic            l_we;
  logic [1:0]      l_swhb;
  logic            l_unsigned;
  logic [XLEN-1:0] l_addr;
  logic [XLEN-1:0] l_wdata;
  logic [XLEN-1:0] rdata_q;
  logic            err_q;

  logic            req_live;
  logic            req_mis;
  logic            accept;
  logic            busy;
  logic [3:0]      be_c;
  logic [XLEN-1:0] wdata_c;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] load_c;

  // Request decode. Gating with reset keeps every combinational output
  // low while the block is held in reset.
  assign req_mis  = ((req_swhb == SZ_HALF) && req_addr[0]) ||
                    ((req_swhb == SZ_WORD) && (req_addr[1:0] != 2'b00));
  assign req_live = reset && (state == S_IDLE) && req_valid &&
                    (req_swhb != SZ_NONE);
  assign accept   = req_live && !req_mis;
  assign misalign = req_live && req_mis;
  assign busy     = reset && (state == S_BUSY);

  assign stall       = accept || busy;
  assign rdata_valid = reset && (state == S_DONE);
  assign bus_err     = rdata_valid && err_q;
  assign rdata       = rdata_q;
  assign state_dbg   = state;

  // Byte enables and lane replication from the latched request.
  always_comb begin
    be_c    = 4'b0000;
    wdata_c = l_wdata;
    case (l_swhb)
      SZ_WORD: begin
        be_c    = 4'b1111;
        wdata_c = l_wdata;
      end
      SZ_HALF: begin
        be_c    = l_addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {(XLEN/16){l_wdata[15:0]}};
      end
      SZ_BYTE: begin
        be_c    = 4'b0001 << l_addr[1:0];
        wdata_c = {(XLEN/8){l_wdata[7:0]}};
      end
      default: begin
        be_c    = 4'b0000;
        wdata_c = l_wdata;
      end
    endcase
  end

  assign bus_req   = busy;
  assign bus_we    = busy && l_we;
  assign bus_addr  = busy ? {l_addr[XLEN-1:2], 2'b00} : '0;
  assign bus_be    = busy ? be_c : 4'b0000;
  assign bus_wdata = busy ? wdata_c : '0;

  // Load extraction: move the addressed lane down to bit 0, then extend.
  assign shifted = bus_rdata >> {l_addr[1:0], 3'b000};

  always_comb begin
    load_c = shifted;
    case (l_swhb)
      SZ_HALF: load_c = l_unsigned ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                   : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      SZ_BYTE: load_c = l_unsigned ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                   : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      default: load_c = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= 8'd0;
      l_we       <= 1'b0;
      l_swhb     <= SZ_NONE;
      l_unsigned <= 1'b0;
      l_addr     <= '0;
      l_wdata    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          err_q <= 1'b0;
          if (accept) begin
            l_we       <= req_we;
            l_swhb     <= req_swhb;
            l_unsigned <= req_unsigned;
            l_addr     <= req_addr;
            l_wdata    <= req_wdata;
            cnt        <= 8'd0;
            state      <= S_BUSY;
          end
        end
        S_BUSY: begin
          // Ack is checked first so a coincident timeout never flags an error.
          if (bus_ack) begin
            rdata_q <= l_we ? '0 : load_c;
            err_q   <= 1'b0;
            state   <= S_DONE;
          end else if (cnt == TIMEOUT_LAST) begin
            cnt     <= cnt + 8'd1;
            rdata_q <= '0;
            err_q   <= 1'b1;
            state   <= S_DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

  localparam int XLEN    = 32;
  localparam int TIMEOUT = 4;

  logic            clk;
  logic            reset;
  logic            req_valid;
  logic            req_we;
  logic [1:0]      req_swhb;
  logic            req_unsigned;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            stall;
  logic            rdata_valid;
  logic [XLEN-1:0] rdata;
  logic            misalign;
  logic            bus_err;
  logic            bus_req;
  logic            bus_we;
  logic [XLEN-1:0] bus_addr;
  logic [3:0]      bus_be;
  logic [XLEN-1:0] bus_wdata;
  logic            bus_ack;
  logic [XLEN-1:0] bus_rdata;
  logic [1:0]      state_dbg;

  int checks = 0;
  int errors = 0;

  lsu_ctrl #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_swhb(req_swhb),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .rdata_valid(rdata_valid), .rdata(rdata),
    .misalign(misalign), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  swhb;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] bus_rd;
    int          ack_at;    // BUSY cycle number carrying bus_ack, 0 = never
    logic        exp_mis;
    logic        exp_bus;   // request goes to the bus
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_busy;  // BUSY cycles
    int          exp_stall; // cycles with stall=1
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int  nbusy;
    int  nstall;
    int  nvalid;
    bit  fin;
    nbusy = 0; nstall = 0; nvalid = 0; fin = 0;
    @(posedge clk); #1;
    req_valid    = 1'b1;
    req_we       = v.we;
    req_swhb     = v.swhb;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    for (int ncyc = 0; ncyc < 40 && !fin; ncyc++) begin
      @(negedge clk);
      if (ncyc == 0) chk({v.name, ".misalign"}, {31'd0, misalign}, {31'd0, v.exp_mis});
      if (stall) nstall++;
      if (bus_req) begin
        nbusy++;
        chk({v.name, ".bus_be"}, {28'd0, bus_be}, {28'd0, v.exp_be});
        chk({v.name, ".bus_we"}, {31'd0, bus_we}, {31'd0, v.we});
        chk({v.name, ".bus_addr"}, bus_addr, v.addr & 32'hFFFF_FFFC);
        if (v.we) chk({v.name, ".bus_wdata"}, bus_wdata, v.exp_wdata);
        bus_ack   = (nbusy == v.ack_at);
        bus_rdata = v.bus_rd;
      end else begin
        bus_ack = 1'b0;
      end
      if (rdata_valid) begin
        nvalid++;
        chk({v.name, ".rdata"}, rdata, v.exp_rdata);
        chk({v.name, ".bus_err"}, {31'd0, bus_err}, {31'd0, v.exp_err});
        fin = 1;
      end
      if (!v.exp_bus && ncyc == 2) fin = 1;
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
    bus_ack = 1'b0;
    if (v.exp_bus && !fin) begin
      checks++; errors++;
      $display("FAIL %s.timeout: no rdata_valid within 40 cycles", v.name);
    end
    @(negedge clk);
    chk({v.name, ".valid_after"}, {31'd0, rdata_valid}, 32'd0);
    chk({v.name, ".nvalid"}, nvalid, v.exp_bus ? 32'd1 : 32'd0);
    chk({v.name, ".busy_cycles"}, nbusy, v.exp_busy);
    chk({v.name, ".stall_cycles"}, nstall, v.exp_stall);
  endtask

  initial begin
    //            name      we  swhb   uns addr          wdata         bus_rd        ack mis bus be       exp_wdata     exp_rdata     err busy stall
    vecs[0]  = '{"lb",      0, 2'b11, 0, 32'h8000_0003, 32'h0,        32'h80FF_1234, 3, 0, 1, 4'b1000, 32'h0,        32'hFFFF_FF80, 0, 3, 4};
    vecs[1]  = '{"lhu",     0, 2'b10, 1, 32'h8000_0002, 32'h0,        32'hBEEF_0000, 1, 0, 1, 4'b1100, 32'h0,        32'h0000_BEEF, 0, 1, 2};
    vecs[2]  = '{"sb",      1, 2'b11, 0, 32'h8000_0001, 32'h0000_00A5, 32'h1234_5678, 1, 0, 1, 4'b0010, 32'hA5A5_A5A5, 32'h0,        0, 1, 2};
    vecs[3]  = '{"lw_mis",  0, 2'b01, 0, 32'h8000_0002, 32'h0,        32'h0,         1, 1, 0, 4'b0000, 32'h0,        32'h0,         0, 0, 0};
    vecs[4]  = '{"lw_tmo",  0, 2'b01, 0, 32'h8000_0000, 32'h0,        32'h0,         0, 0, 1, 4'b1111, 32'h0,        32'h0,         1, 4, 5};
    vecs[5]  = '{"lh",      0, 2'b10, 0, 32'h8000_0000, 32'h0,        32'h1234_8001, 2, 0, 1, 4'b0011, 32'h0,        32'hFFFF_8001, 0, 2, 3};
    vecs[6]  = '{"lbu",     0, 2'b11, 1, 32'h8000_0001, 32'h0,        32'h0000_F500, 1, 0, 1, 4'b0010, 32'h0,        32'h0000_00F5, 0, 1, 2};
    vecs[7]  = '{"sh",      1, 2'b10, 0, 32'h8000_0002, 32'h1234_ABCD, 32'h0,         1, 0, 1, 4'b1100, 32'hABCD_ABCD, 32'h0,        0, 1, 2};
    vecs[8]  = '{"sw",      1, 2'b01, 0, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0,         1, 0, 1, 4'b1111, 32'hDEAD_BEEF, 32'h0,        0, 1, 2};
    vecs[9]  = '{"lh_mis",  0, 2'b10, 0, 32'h8000_0001, 32'h0,        32'h0,         1, 1, 0, 4'b0000, 32'h0,        32'h0,         0, 0, 0};
    vecs[10] = '{"lw_ackto",0, 2'b01, 0, 32'h8000_0008, 32'h0,        32'hCAFE_F00D, 4, 0, 1, 4'b1111, 32'h0,        32'hCAFE_F00D, 0, 4, 5};
    vecs[11] = '{"none",    0, 2'b00, 0, 32'h8000_0003, 32'h0,        32'h0,         1, 0, 0, 4'b0000, 32'h0,        32'h0,         0, 0, 0};
    vecs[12] = '{"sb3",     1, 2'b11, 0, 32'h8000_0003, 32'h0000_125A, 32'h0,         1, 0, 1, 4'b1000, 32'h5A5A_5A5A, 32'h0,        0, 1, 2};

    reset = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_swhb = 2'b01;
    req_unsigned = 1'b0; req_addr = 32'h8000_0000; req_wdata = '0;
    bus_ack = 1'b0; bus_rdata = '0;

    // reset state, with a request presented during reset
    #12;
    chk("rst.stall", {31'd0, stall}, 32'd0);
    chk("rst.bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst.rdata", rdata, 32'd0);
    chk("rst.state", {30'd0, state_dbg}, 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // bus_ack outside BUSY has no effect
    @(posedge clk); #1;
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("stray_ack.state", {30'd0, state_dbg}, 32'd0);
      chk("stray_ack.valid", {31'd0, rdata_valid}, 32'd0);
    end
    @(posedge clk); #1;
    bus_ack = 1'b0;

    // req_valid held through DONE must not restart an access
    req_valid = 1'b1; req_we = 1'b0; req_swhb = 2'b01; req_unsigned = 1'b0;
    req_addr = 32'h8000_0020;
    @(posedge clk); #1;
    bus_ack = 1'b1; bus_rdata = 32'h0123_4567;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    chk("done_hold.valid", {31'd0, rdata_valid}, 32'd1);
    chk("done_hold.rdata", rdata, 32'h0123_4567);
    chk("done_hold.stall", {31'd0, stall}, 32'd0);
    chk("done_hold.bus_req", {31'd0, bus_req}, 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("done_hold.state", {30'd0, state_dbg}, 32'd0);
    chk("done_hold.bus_req2", {31'd0, bus_req}, 32'd0);

    // reset asserted mid-BUSY
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 32'h8000_0010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst.bus_req_before", {31'd0, bus_req}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst.bus_req", {31'd0, bus_req}, 32'd0);
    chk("mid_rst.stall", {31'd0, stall}, 32'd0);
    chk("mid_rst.state", {30'd0, state_dbg}, 32'd0);
    chk("mid_rst.bus_be", {28'd0, bus_be}, 32'd0);
    chk("mid_rst.rdata", rdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mid_rst.no_valid", {31'd0, rdata_valid}, 32'd0);
      chk("mid_rst.idle", {30'd0, state_dbg}, 32'd0);
    end
    run_vec('{"lw_fresh", 0, 2'b01, 0, 32'h8000_0010, 32'h0, 32'h5555_AAAA, 1, 0, 1,
              4'b1111, 32'h0, 32'h5555_AAAA, 0, 1, 2});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
